tinker_regfile_sb: RTL

Parametrised register file with a pending-write scoreboard, for the multi-cycle tinker core. It adds a configurable number of read ports, same-cycle write-to-read bypass, and per-register busy tracking. Issue logic uses the busy tracking to stall on RAW and WAW hazards while long-latency units (div, FPU, load) are in flight. It sits between decode/issue and the ALU/FPU/LSU write-back bus.

---
 rtl/tinker_regfile_sb.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/tinker_regfile_sb.sv
// ---------------------------------------------------------------------------
// tinker_regfile_sb
//
// Architectural register file for the multi-cycle tinker core, with a
// pending-write scoreboard. Decode/issue reads operands through NUM_RD
// combinational ports. Long-latency units (div, FPU, load) mark their
// destination busy at dispatch. The write-back bus clears that mark when
// the result returns.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   rd_addr        NUM_RD packed read addresses, port i at [i*AW +: AW]
//   rd_data        NUM_RD packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy        per-port: addressed register still has a write in flight
//   issue_en/addr  request to mark a destination pending
//   issue_ok       the request is accepted this cycle
//   wr_en/addr/data write-back bus
//   busy_vec       registered scoreboard, one bit per register
//   pending_cnt    registered popcount of busy_vec
// ---------------------------------------------------------------------------

// One read port: out-of-range guard, write-back bypass, busy lookup.
module tinker_regfile_sb_rdport #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter bit BYPASS   = 1'b1
) (
    input  logic [AW-1:0]                    addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic [NUM_REGS-1:0]              busy_vec,
    input  logic                             wr_en,
    input  logic [AW-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    output logic [DATA_W-1:0]                data,
    output logic                             busy
);
    localparam logic [AW:0] LIMIT = (AW+1)'(NUM_REGS);

    logic in_range;
    assign in_range = ({1'b0, addr} < LIMIT);

    always_comb begin
        data = '0;
        busy = 1'b0;
        if (in_range) begin
            // A result landing this cycle is, by definition, no longer pending.
            if (BYPASS && wr_en && (wr_addr == addr)) begin
                data = wr_data;
            end else begin
                data = regs[addr];
                busy = busy_vec[addr];
            end
        end
    end
endmodule

module tinker_regfile_sb #(
    parameter int              DATA_W   = 64,
    parameter int              NUM_REGS = 32,
    parameter int              NUM_RD   = 3,
    parameter logic [DATA_W-1:0] SP_INIT = 64'h80000,
    parameter bit              BYPASS   = 1'b1,
    localparam int             AW       = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*AW-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       issue_en,
    input  logic [AW-1:0]              issue_addr,
    output logic                       issue_ok,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [NUM_REGS-1:0]        busy_vec,
    output logic [AW:0]                pending_cnt
);
    localparam logic [AW:0] LIMIT = (AW+1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    // Address qualification only matters when NUM_REGS is not a power of 2.
    logic wr_in_range, iss_in_range;
    assign wr_in_range  = ({1'b0, wr_addr}    < LIMIT);
    assign iss_in_range = ({1'b0, issue_addr} < LIMIT);

    logic wr_fire;       // write-back that actually updates state
    logic wr_was_busy;   // target of write-back is currently marked
    logic iss_was_busy;  // target of issue is currently marked
    logic same_addr;

    assign wr_fire      = wr_en && wr_in_range;
    assign wr_was_busy  = wr_in_range  ? busy_vec[wr_addr]    : 1'b0;
    assign iss_was_busy = iss_in_range ? busy_vec[issue_addr] : 1'b0;
    assign same_addr    = (wr_addr == issue_addr);

    // WAW guard: a pending destination may be re-issued only in the cycle
    // its outstanding result retires.
    assign issue_ok = issue_en && iss_in_range && (!iss_was_busy || (wr_fire && same_addr));

    // Counter deltas follow actual bit transitions so the count always
    // equals popcount(busy_vec). A set overriding a same-address clear is
    // no transition at all.
    logic cnt_inc, cnt_dec;
    assign cnt_inc = issue_ok && !iss_was_busy;
    assign cnt_dec = wr_fire && wr_was_busy && !(issue_ok && same_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs                 <= '0;
            regs[NUM_REGS-1]     <= SP_INIT;
            busy_vec             <= '0;
            pending_cnt          <= '0;
        end else begin
            if (wr_fire) begin
                regs[wr_addr]     <= wr_data;
                busy_vec[wr_addr] <= 1'b0;
            end
            // Later assignment wins: a same-cycle issue re-marks the register.
            if (issue_ok)
                busy_vec[issue_addr] <= 1'b1;
            pending_cnt <= pending_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        tinker_regfile_sb_rdport #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .AW       (AW),
            .BYPASS   (BYPASS)
        ) u_port (
            .addr     (rd_addr[i*AW +: AW]),
            .regs     (regs),
            .busy_vec (busy_vec),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rd_data[i*DATA_W +: DATA_W]),
            .busy     (rd_busy[i])
        );
    end
endmodule
